ram_stream_reader: RTL and testbench

//   Read-side controller for the dual-port distributed RAM (raminfr). Once the write side has

---
 rtl/ram_stream_reader.sv | 121 ++++++++++++
 tb/tb_ram_stream_reader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Read-side controller for a dual-port distributed RAM.
// Streams a burst of consecutive words, starting at a base address, from the
// RAM's asynchronous read port onto a valid/ready interface. A one-entry
// output register sustains one word per clock and absorbs backpressure.
module ram_stream_reader #(
    parameter int AW = 5,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic [AW-1:0] dpra,
    input  logic [DW-1:0] dpo,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   REM_ONE = 1;
    localparam logic [AW:0]   REM_ZERO = 0;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          done_q, done_d;
    logic          load;

    // A word is captured from the RAM whenever words remain and the output slot is free or emptying
    always_comb begin
        load = (state_q == READ) && (remaining_q != REM_ZERO) && (!m_valid_q || m_ready);
    end

    // Next-state logic: the output slot is handled first, then the FSM may override pointer/count
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        done_d      = 1'b0;

        if (load) begin
            m_data_d    = dpo;
            m_valid_d   = 1'b1;
            ptr_d       = ptr_q + PTR_ONE;
            remaining_d = remaining_q - REM_ONE;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d       = base_addr;
                    remaining_d = len;
                    if (len != REM_ZERO) begin
                        state_d = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (load && (remaining_q == REM_ONE)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (m_valid_q && m_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any burst without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            done_q      <= done_d;
        end
    end

    // Outputs come straight from registers so the RAM address has no path from the inputs
    always_comb begin
        dpra    = ptr_q;
        m_data  = m_data_q;
        m_valid = m_valid_q;
        busy    = (state_q != IDLE);
        done    = done_q;
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Testbench for ram_stream_reader: a behavioural RAM, a queue scoreboard fed
// when each burst is requested, and an independent monitor that checks every
// transfer, output stability under backpressure and the done pulse.
module tb_ram_stream_reader;

    localparam int AW    = 5;
    localparam int DW    = 4;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic [AW-1:0] dpra;
    logic [DW-1:0] dpo;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] expQ [$];
    logic [DW-1:0] expWord;
    logic [DW-1:0] prevData = '0;

    int compared = 0;
    int mismatched = 0;
    int readyMode = 0;
    int stallLeft = 0;
    int cycle = 0;
    int xferCount = 0;
    int firstXfer = -1;
    int lastXfer = -1;
    bit stallUsed = 1'b0;
    bit zeroLenExpect = 1'b0;
    bit prevFinal = 1'b0;
    bit prevStall = 1'b0;
    bit doneExp = 1'b0;

    ram_stream_reader #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .dpra      (dpra),
        .dpo       (dpo),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done)
    );

    // Asynchronous RAM read port
    assign dpo = mem[dpra];

    // Free-running clock with a cycle counter for throughput measurement
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic loadPattern();
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        mem[3]  = 4'b1010;
        mem[10] = 4'b1100;
        mem[15] = 4'b1111;
    endtask

    // Sink behaviour: always ready, random, or a single 3-clock stall on the first valid word
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: m_ready = 1'b1;
                1: m_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (stallLeft > 0) begin
                        m_ready = 1'b0;
                        stallLeft--;
                    end else if (m_valid && !stallUsed) begin
                        stallUsed = 1'b1;
                        stallLeft = 2;
                        m_ready = 1'b0;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on every transfer and checks hold and done behaviour
    always @(negedge clk) begin
        if (!rst_n) begin
            prevFinal = 1'b0;
            prevStall = 1'b0;
        end else begin
            doneExp = prevFinal || zeroLenExpect;
            if (done || doneExp) checkOutput("done", done, doneExp);
            if (prevStall) begin
                checkOutput("holdValid", m_valid, 1);
                checkOutput("holdData", m_data, prevData);
            end
            prevFinal = 1'b0;
            if (m_valid && m_ready) begin
                xferCount++;
                if (firstXfer < 0) firstXfer = cycle;
                lastXfer = cycle;
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpectedWord: got %0d, expected no transfer", m_data);
                end else begin
                    expWord = expQ.pop_front();
                    checkOutput("data", m_data, expWord);
                    prevFinal = (expQ.size() == 0);
                end
            end
            prevStall = m_valid && !m_ready;
            prevData = m_data;
        end
    end

    task automatic applyStimulus(input int b, input int l, input int mode, input bit pokeBusy);
        bit got;
        readyMode = mode;
        stallUsed = 1'b0;
        stallLeft = 0;
        firstXfer = -1;
        lastXfer = -1;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = AW'(b);
        len = (AW + 1)'(l);
        for (int i = 0; i < l; i++) expQ.push_back(mem[(b + i) % DEPTH]);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (l == 0) begin
            zeroLenExpect = 1'b1;
            @(negedge clk);
            checkOutput("zeroLenValid", m_valid, 0);
            checkOutput("zeroLenBusy", busy, 0);
            @(posedge clk);
            #1;
            zeroLenExpect = 1'b0;
            @(negedge clk);
            checkOutput("zeroLenDoneOnce", done, 0);
        end else begin
            @(negedge clk);
            checkOutput("dpra", dpra, b % DEPTH);
            checkOutput("busy", busy, 1);
            if (pokeBusy) begin
                @(posedge clk);
                #1;
                start = 1'b1;
                base_addr = '0;
                len = 6'd5;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            got = 1'b0;
            for (int c = 0; c < 400 && !got; c++) begin
                @(negedge clk);
                if (done) got = 1'b1;
            end
            if (!got) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL doneTimeout: got no done, expected done within 400 cycles (base %0d len %0d)", b, l);
                expQ.delete();
            end else begin
                checkOutput("burstDrained", expQ.size(), 0);
                checkOutput("busyAfterDone", busy, 0);
                if (mode == 0) checkOutput("backToBack", lastXfer - firstXfer, l - 1);
            end
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed bursts, random bursts, reset mid-burst
    initial begin
        int b0;
        int rb;
        int rl;
        int rm;
        bit got;
        loadPattern();
        #12;
        checkOutput("resetValid", m_valid, 0);
        checkOutput("resetData", m_data, 0);
        checkOutput("resetDpra", dpra, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", done, 0);
        #11;
        rst_n = 1'b1;

        applyStimulus(3, 1, 0, 1'b0);
        applyStimulus(9, 7, 0, 1'b1);
        applyStimulus(30, 4, 0, 1'b0);
        applyStimulus(10, 3, 2, 1'b0);
        applyStimulus(5, 0, 0, 1'b0);
        applyStimulus(7, 32, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(0, 15));
            rb = $urandom_range(0, DEPTH - 1);
            rl = $urandom_range(0, DEPTH);
            rm = $urandom_range(0, 1);
            applyStimulus(rb, rl, rm, 1'b0);
        end

        loadPattern();
        readyMode = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = '0;
        len = 6'd8;
        for (int i = 0; i < 8; i++) expQ.push_back(mem[i]);
        b0 = xferCount;
        @(posedge clk);
        #1;
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (xferCount - b0 >= 2) got = 1'b1;
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL midBurstWords: got %0d words, expected 2 before reset", xferCount - b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abortValid", m_valid, 0);
        checkOutput("abortData", m_data, 0);
        checkOutput("abortDpra", dpra, 0);
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortDone", done, 0);
        expQ.delete();
        #20;
        rst_n = 1'b1;
        applyStimulus(3, 1, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
